// File: rtl/adat_pkg.sv
// rtl/adat_pkg.sv - shared ADAT frame constants and types for the transmitter and its scheduler
package adat_pkg;

    localparam int ADAT_FRAME_CLKS = 256;
    localparam int ADAT_SLOTS      = 8;
    localparam int ADAT_SAMPLE_W   = 24;

    typedef logic signed [ADAT_SAMPLE_W-1:0] adat_sample_t;
    typedef adat_sample_t [0:ADAT_SLOTS-1] adat_frame_t;

    typedef struct packed {
        logic timecode;
        logic midi;
        logic smux;
    } adat_user_t;

endpackage

// File: rtl/adat_frame_timer.sv
// rtl/adat_frame_timer.sv - ADAT frame phase counter with swap strobe and next-frame request pulse
module adat_frame_timer #(
    parameter  int FRAME_CLKS = 256,
    localparam int PHASE_W    = $clog2(FRAME_CLKS)
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [PHASE_W-1:0] phase_o,
    output logic               swap_o,
    output logic               frame_req_o
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               frame_req_q, frame_req_d;

    // FRAME_CLKS is a power of two, so the counter wraps on its own.
    always_comb begin
        phase_d     = phase_q + PHASE_W'(1);
        frame_req_d = (phase_q == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q     <= '0;
            frame_req_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            frame_req_q <= frame_req_d;
        end
    end

    assign phase_o     = phase_q;
    assign swap_o      = (phase_q == PHASE_W'(FRAME_CLKS - 1));
    assign frame_req_o = frame_req_q;

endmodule

// File: rtl/adat_tx_scheduler.sv
// rtl/adat_tx_scheduler.sv - collects per-slot samples and swaps them into a stable bank at each ADAT frame boundary
module adat_tx_scheduler
    import adat_pkg::*;
#(
    parameter  int FRAME_CLKS       = ADAT_FRAME_CLKS,
    parameter  int SAMPLE_W         = ADAT_SAMPLE_W,
    parameter  int N_SLOTS          = ADAT_SLOTS,
    parameter  int HOLD_ON_UNDERRUN = 0,
    localparam int PHASE_W          = $clog2(FRAME_CLKS),
    localparam int SLOT_W           = $clog2(N_SLOTS)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [SLOT_W-1:0]                 in_slot,
    input  logic [SAMPLE_W-1:0]               in_sample,
    input  logic                              user_timecode,
    input  logic                              user_midi,
    input  logic                              user_smux,
    output logic [N_SLOTS-1:0][SAMPLE_W-1:0]  audio_out,
    output logic                              timecode_out,
    output logic                              midi_out,
    output logic                              smux_out,
    output logic [PHASE_W-1:0]                frame_phase,
    output logic                              frame_req,
    output logic                              underrun_flag,
    output logic                              overrun_flag,
    input  logic                              flag_clear
);

    logic [PHASE_W-1:0] phase;
    logic               swap;
    logic               accept;

    logic [N_SLOTS-1:0][SAMPLE_W-1:0] pending_q, pending_d;
    logic [N_SLOTS-1:0][SAMPLE_W-1:0] audio_q, audio_d;
    logic [N_SLOTS-1:0]               written_q, written_d;
    adat_user_t                       user_q, user_d;
    logic                             armed_q, armed_d;
    logic                             underrun_q, underrun_d;
    logic                             overrun_q, overrun_d;
    logic                             underrun_set;
    logic                             overrun_set;

    adat_frame_timer #(
        .FRAME_CLKS (FRAME_CLKS)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .phase_o     (phase),
        .swap_o      (swap),
        .frame_req_o (frame_req)
    );

    // Refusing samples on the swap cycle keeps writes and the bank swap disjoint.
    assign in_ready = reset_n & ~swap;
    assign accept   = in_valid & in_ready;

    always_comb begin
        pending_d    = pending_q;
        audio_d      = audio_q;
        written_d    = written_q;
        user_d       = user_q;
        armed_d      = armed_q;
        underrun_set = 1'b0;
        overrun_set  = 1'b0;

        if (accept) begin
            pending_d[in_slot] = in_sample;
            written_d[in_slot] = 1'b1;
            overrun_set        = written_q[in_slot];
            armed_d            = 1'b1;
        end

        // Underruns only count once upstream has delivered anything, so idle start-up frames are quiet.
        if (swap) begin
            for (int s = 0; s < N_SLOTS; s++) begin
                if (written_q[s]) begin
                    audio_d[s] = pending_q[s];
                end else begin
                    if (HOLD_ON_UNDERRUN == 0) begin
                        audio_d[s] = '0;
                    end
                    underrun_set = underrun_set | armed_q;
                end
            end
            written_d       = '0;
            user_d.timecode = user_timecode;
            user_d.midi     = user_midi;
            user_d.smux     = user_smux;
        end

        underrun_d = underrun_set | (underrun_q & ~flag_clear);
        overrun_d  = overrun_set | (overrun_q & ~flag_clear);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= '0;
            audio_q    <= '0;
            written_q  <= '0;
            user_q     <= '0;
            armed_q    <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            audio_q    <= audio_d;
            written_q  <= written_d;
            user_q     <= user_d;
            armed_q    <= armed_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    assign audio_out     = audio_q;
    assign timecode_out  = user_q.timecode;
    assign midi_out      = user_q.midi;
    assign smux_out      = user_q.smux;
    assign frame_phase   = phase;
    assign underrun_flag = underrun_q;
    assign overrun_flag  = overrun_q;

endmodule

// File: tb/tb_adat_tx_scheduler.sv
// tb/tb_adat_tx_scheduler.sv - self-checking bench for adat_tx_scheduler, zero-fill and hold variants side by side
module tb_adat_tx_scheduler;

    localparam int FC = 256;
    typedef logic [7:0][23:0] frame_t;

    typedef struct {
        logic [7:0] wmask;
        logic [2:0] user;
        frame_t     wv;
        frame_t     exp0;
        frame_t     exp1;
        logic       exp_unf;
    } fvec_t;

    typedef struct {
        frame_t a0;
        frame_t a1;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_slot = '0;
    logic [23:0] in_sample = '0;
    logic        ut = 1'b0, um = 1'b0, us = 1'b0;
    logic        flag_clear = 1'b0;

    logic        rdy0, rdy1, req0, req1, unf0, unf1, ovf0, ovf1;
    logic        tc0, md0, sm0, tc1, md1, sm1;
    logic [7:0]  ph0, ph1;
    frame_t      audio0, audio1;

    int n_vec = 0;
    int n_err = 0;

    int         m_ph;
    frame_t     m_pend, m_cur0, m_cur1;
    logic [7:0] m_wr;
    logic [2:0] m_user;
    logic       m_unf, m_ovf, m_armed;
    sb_t        sb_q[$];
    fvec_t      vec[3];

    adat_tx_scheduler #(.HOLD_ON_UNDERRUN(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_slot(in_slot), .in_sample(in_sample),
        .user_timecode(ut), .user_midi(um), .user_smux(us),
        .audio_out(audio0), .timecode_out(tc0), .midi_out(md0), .smux_out(sm0),
        .frame_phase(ph0), .frame_req(req0),
        .underrun_flag(unf0), .overrun_flag(ovf0), .flag_clear(flag_clear)
    );

    adat_tx_scheduler #(.HOLD_ON_UNDERRUN(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_slot(in_slot), .in_sample(in_sample),
        .user_timecode(ut), .user_midi(um), .user_smux(us),
        .audio_out(audio1), .timecode_out(tc1), .midi_out(md1), .smux_out(sm1),
        .frame_phase(ph1), .frame_req(req1),
        .underrun_flag(unf1), .overrun_flag(ovf1), .flag_clear(flag_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic void chk_b(string nm, logic act, logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endfunction

    function automatic void chk_n(string nm, logic [23:0] act, logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void chk_f(string nm, frame_t act, frame_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    function automatic frame_t ramp(logic [23:0] base);
        frame_t f;
        for (int s = 0; s < 8; s++) f[s] = base + 24'(s);
        return f;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_pend = '0; m_cur0 = '0; m_cur1 = '0; m_wr = '0;
        m_user = '0; m_unf = 1'b0; m_ovf = 1'b0; m_armed = 1'b0;
        sb_q.delete();
    endtask

    task automatic check_state();
        chk_n("phase0", 24'(ph0), 24'(m_ph));
        chk_n("phase1", 24'(ph1), 24'(m_ph));
        chk_b("ready0", rdy0, m_ph != FC - 1);
        chk_b("ready1", rdy1, m_ph != FC - 1);
        chk_b("req0", req0, m_ph == 1);
        chk_b("req1", req1, m_ph == 1);
        chk_f("audio0", audio0, m_cur0);
        chk_f("audio1", audio1, m_cur1);
        chk_b("unf0", unf0, m_unf);
        chk_b("unf1", unf1, m_unf);
        chk_b("ovf0", ovf0, m_ovf);
        chk_b("ovf1", ovf1, m_ovf);
        chk_n("user0", 24'({tc0, md0, sm0}), 24'(m_user));
        chk_n("user1", 24'({tc1, md1, sm1}), 24'(m_user));
    endtask

    task automatic check_zero(string tag);
        chk_f({tag, "_audio0"}, audio0, '0);
        chk_f({tag, "_audio1"}, audio1, '0);
        chk_n({tag, "_phase"}, 24'(ph0), 24'd0);
        chk_b({tag, "_ready"}, rdy0 | rdy1, 1'b0);
        chk_b({tag, "_req"}, req0 | req1, 1'b0);
        chk_b({tag, "_flags"}, unf0 | unf1 | ovf0 | ovf1, 1'b0);
        chk_n({tag, "_user"}, 24'({tc0, md0, sm0, tc1, md1, sm1}), 24'd0);
    endtask

    // One clock: the model predicts the edge from the inputs in force, then the DUT state is compared.
    task automatic tick();
        logic acc, swp, set_o, set_u;
        sb_t  e;
        acc   = in_valid && (m_ph != FC - 1);
        swp   = (m_ph == FC - 1);
        set_o = acc && m_wr[in_slot];
        set_u = 1'b0;
        @(posedge clk);
        if (acc) begin
            m_pend[in_slot] = in_sample;
            m_wr[in_slot]   = 1'b1;
            m_armed         = 1'b1;
        end
        if (swp) begin
            for (int s = 0; s < 8; s++) begin
                if (m_wr[s]) begin
                    e.a0[s] = m_pend[s];
                    e.a1[s] = m_pend[s];
                end else begin
                    e.a0[s] = '0;
                    e.a1[s] = m_cur1[s];
                    if (m_armed) set_u = 1'b1;
                end
            end
            m_wr   = '0;
            m_user = {ut, um, us};
            sb_q.push_back(e);
        end
        m_ovf = set_o | (m_ovf & ~flag_clear);
        m_unf = set_u | (m_unf & ~flag_clear);
        m_ph  = (m_ph + 1) % FC;
        #1;
        if (m_ph == 0) begin
            chk_b("sb_pending", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                m_cur0 = e.a0;
                m_cur1 = e.a1;
            end
        end
        check_state();
    endtask

    task automatic wr(input logic [2:0] slot, input logic [23:0] val);
        in_valid  = 1'b1;
        in_slot   = slot;
        in_sample = val;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic apply_reset(string tag);
        reset_n = 1'b0;
        #1;
        check_zero({tag, "_async"});
        repeat (3) @(posedge clk);
        #1;
        check_zero({tag, "_held"});
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int req_cyc[$];
        int rdy_low[$];
        int exp_req[3];
        int exp_low[2];

        vec[0].wmask = 8'hFF; vec[0].user = 3'b101;
        vec[0].wv = ramp(24'h100000); vec[0].exp0 = vec[0].wv; vec[0].exp1 = vec[0].wv;
        vec[0].exp_unf = 1'b0;
        vec[1].wmask = 8'hFF; vec[1].user = 3'b010;
        vec[1].wv = ramp(24'h200000); vec[1].wv[6] = 24'h7FFFFF; vec[1].wv[7] = 24'h7FFFFF;
        vec[1].exp0 = vec[1].wv; vec[1].exp1 = vec[1].wv; vec[1].exp_unf = 1'b0;
        vec[2].wmask = 8'h3F; vec[2].user = 3'b111;
        vec[2].wv = ramp(24'h300000);
        vec[2].exp0 = ramp(24'h300000); vec[2].exp0[6] = '0; vec[2].exp0[7] = '0;
        vec[2].exp1 = ramp(24'h300000); vec[2].exp1[6] = 24'h7FFFFF; vec[2].exp1[7] = 24'h7FFFFF;
        vec[2].exp_unf = 1'b1;
        exp_req = '{1, 257, 513};
        exp_low = '{255, 511};

        model_reset();
        apply_reset("por");

        for (int c = 1; c <= 600; c++) begin
            tick();
            if (req0) req_cyc.push_back(c);
            if (!rdy0) rdy_low.push_back(c);
        end
        chk_n("req_count", 24'(req_cyc.size()), 24'd3);
        for (int i = 0; i < 3; i++)
            chk_n("req_cycle", 24'(i < req_cyc.size() ? req_cyc[i] : -1), 24'(exp_req[i]));
        chk_n("ready_low_count", 24'(rdy_low.size()), 24'd2);
        for (int i = 0; i < 2; i++)
            chk_n("ready_low_cycle", 24'(i < rdy_low.size() ? rdy_low[i] : -1), 24'(exp_low[i]));

        while (m_ph != 0) tick();

        for (int v = 0; v < 3; v++) begin
            {ut, um, us} = vec[v].user;
            for (int s = 0; s < 8; s++)
                if (vec[v].wmask[s]) wr(3'(s), vec[v].wv[s]);
            while (m_ph != 0) tick();
            for (int s = 0; s < 8; s++) begin
                chk_n("vec_audio0", audio0[s], vec[v].exp0[s]);
                chk_n("vec_audio1", audio1[s], vec[v].exp1[s]);
            end
            chk_b("vec_unf0", unf0, vec[v].exp_unf);
            chk_b("vec_unf1", unf1, vec[v].exp_unf);
            chk_b("vec_ovf", ovf0 | ovf1, 1'b0);
            chk_n("vec_user", 24'({tc0, md0, sm0}), 24'(vec[v].user));
        end

        flag_clear = 1'b1;
        tick();
        flag_clear = 1'b0;
        chk_b("unf_cleared", unf0 | unf1, 1'b0);

        wr(3'd3, 24'h000001);
        chk_b("ovf_after_first", ovf0, 1'b0);
        wr(3'd3, 24'hFFFFFF);
        chk_b("ovf_set", ovf0 & ovf1, 1'b1);
        flag_clear = 1'b1;
        wr(3'd3, 24'hFFFFFF);
        flag_clear = 1'b0;
        chk_b("ovf_set_wins", ovf0 & ovf1, 1'b1);
        flag_clear = 1'b1;
        tick();
        flag_clear = 1'b0;
        chk_b("ovf_clear", ovf0 | ovf1, 1'b0);
        while (m_ph != 0) tick();
        chk_n("ovf_last_wins0", audio0[3], 24'hFFFFFF);
        chk_n("ovf_last_wins1", audio1[3], 24'hFFFFFF);

        while (m_ph != 254) tick();
        in_valid  = 1'b1;
        in_slot   = 3'd2;
        in_sample = 24'h0AAAAA;
        tick();
        chk_b("ready_255", rdy0, 1'b0);
        in_sample = 24'h0BBBBB;
        tick();
        chk_n("bnd_254_next0", audio0[2], 24'h0AAAAA);
        chk_n("bnd_254_next1", audio1[2], 24'h0AAAAA);
        in_sample = 24'h0CCCCC;
        tick();
        in_valid = 1'b0;
        while (m_ph != 0) tick();
        chk_n("bnd_0_later0", audio0[2], 24'h0CCCCC);
        chk_n("bnd_0_later1", audio1[2], 24'h0CCCCC);

        while (m_ph != 100) tick();
        apply_reset("mid");
        tick();
        chk_n("rst_phase", 24'(ph0), 24'd1);
        chk_b("rst_req", req0 & req1, 1'b1);
        repeat (300) tick();
        chk_b("rst_no_unf", unf0 | unf1, 1'b0);
        chk_f("rst_zero_frame", audio0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
